// File: rtl/c1_csum_ctrl.sv
// ============================================================================
// c1_csum_ctrl : ones' complement checksum controller over a valid/ready stream
// Optional block-verify flag enabled by defining C1_CSUM_VERIFY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module c1_csum_ctrl #(
  parameter int W  = 4,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  csum,
  output logic          chk_ok
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [W-1:0]  r_acc;
  logic [LW-1:0] r_cnt;
  logic [W-1:0]  r_csum;

  logic [W:0]    w_raw;
  logic [W-1:0]  w_sum;
  logic          w_xfer;
  logic          w_last;

  // End-around carry: folding the carry back in cannot carry out again.
  assign w_raw  = {1'b0, r_acc} + {1'b0, in_data};
  assign w_sum  = w_raw[W-1:0] + W'(w_raw[W]);
  assign w_xfer = (r_state == S_ACC) && in_valid;
  assign w_last = w_xfer && (r_cnt == LW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_csum  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc <= '0;
            if (len != '0) begin
              r_cnt   <= len;
              r_state <= S_ACC;
            end else begin
              r_csum  <= {W{1'b1}};
              r_state <= S_DONE;
            end
          end
        end
        S_ACC: begin
          if (w_xfer) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt - LW'(1);
            // Checksum is captured on the last transfer so it is valid alongside done.
            if (w_last) begin
              r_csum  <= ~w_sum;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = (r_state == S_ACC);
  assign busy     = (r_state == S_ACC) || (r_state == S_DONE);
  assign done     = (r_state == S_DONE);
  assign csum     = r_csum;

`ifdef C1_CSUM_VERIFY_EN
  logic r_chk_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chk_ok <= 1'b0;
    end else if ((r_state == S_IDLE) && start && (len == '0)) begin
      r_chk_ok <= 1'b0;
    end else if (w_last) begin
      r_chk_ok <= (w_sum == {W{1'b1}});
    end
  end

  assign chk_ok = r_chk_ok;
`else
  assign chk_ok = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_c1_csum_ctrl.sv
// ============================================================================
// tb_c1_csum_ctrl : directed vector table plus sequences for c1_csum_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_c1_csum_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [3:0] csum;
  logic       chk_ok;

`ifdef C1_CSUM_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  c1_csum_ctrl #(.W(4), .LW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .csum     (csum),
    .chk_ok   (chk_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [3:0] w [15];
    int         gap;
    logic [3:0] exp_csum;
    logic       exp_chk;
    string      name;
  } vec_t;

  vec_t       vecs [12];
  int         nvec;
  logic [3:0] cur_w [15];
  int         n_cmp;
  int         n_bad;
  int         blk_dones;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (done) blk_dones++;
  endtask

  task automatic add(input int n, input logic [3:0] w0, input logic [3:0] w1,
                     input logic [3:0] w2, input logic [3:0] rest, input int gap,
                     input logic [3:0] cs, input logic ck, input string nm);
    vecs[nvec].n = n;
    for (int i = 0; i < 15; i++) vecs[nvec].w[i] = rest;
    vecs[nvec].w[0]     = w0;
    vecs[nvec].w[1]     = w1;
    vecs[nvec].w[2]     = w2;
    vecs[nvec].gap      = gap;
    vecs[nvec].exp_csum = cs;
    vecs[nvec].exp_chk  = ck;
    vecs[nvec].name     = nm;
    nvec++;
  endtask

  // Called at a negedge; issues start immediately so consecutive calls are back-to-back.
  task automatic run_block(input int n, input int gap, input bit junk,
                           input logic [3:0] exp_cs, input logic exp_ck, input string nm);
    blk_dones = 0;
    start = 1'b1;
    len   = 4'(n);
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          in_data  = 4'($urandom);
          step();
        end
      end
      chk({nm, " in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      in_data  = cur_w[i];
      if (junk && i == 0) begin
        start = 1'b1;
        len   = 4'd5;
      end
      step();
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 4'($urandom);
    end
    chk({nm, " done"}, done, 1);
    chk({nm, " busy_done"}, busy, 1);
    chk({nm, " in_ready_done"}, in_ready, 0);
    chk({nm, " csum"}, csum, exp_cs);
    chk({nm, " chk_ok"}, chk_ok, exp_ck & VER);
    if (junk) begin
      start = 1'b1;
      len   = 4'd5;
    end
    step();
    start = 1'b0;
    chk({nm, " done_drop"}, done, 0);
    chk({nm, " busy_idle"}, busy, 0);
    chk({nm, " done_count"}, blk_dones, 1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nvec  = 0;
    blk_dones = 0;
    rst = 1'b1;
    start = 1'b0;
    len = 4'd0;
    in_data = 4'd0;
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset done", done, 0);
    chk("reset csum", csum, 0);
    chk("reset chk_ok", chk_ok, 0);

    // Reset in the middle of a block discards the partial sum.
    start = 1'b1;
    len   = 4'd3;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'b0111;
    step();
    in_valid = 1'b0;
    chk("midblk busy_before", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst busy", busy, 0);
    chk("midrst in_ready", in_ready, 0);
    chk("midrst done", done, 0);
    chk("midrst csum", csum, 0);
    step();
    chk("midrst idle_done", done, 0);
    cur_w[0] = 4'b0011;
    run_block(1, 0, 1'b0, 4'b1100, 1'b0, "after_rst");

    add(2,  4'h5, 4'h6, 4'h0, 4'h0, 0, 4'h4, 1'b0, "nocarry");
    add(2,  4'hC, 4'hA, 4'h0, 4'h0, 0, 4'h8, 1'b0, "eac1");
    add(2,  4'hF, 4'h1, 4'h0, 4'h0, 0, 4'hE, 1'b0, "eac2");
    add(3,  4'h1, 4'h2, 4'h4, 4'h0, 2, 4'h8, 1'b0, "stall");
    add(0,  4'h0, 4'h0, 4'h0, 4'h0, 0, 4'hF, 1'b0, "len0");
    add(3,  4'h5, 4'h6, 4'h4, 4'h0, 0, 4'h0, 1'b1, "verify_ok");
    add(3,  4'h5, 4'h6, 4'h5, 4'h0, 0, 4'hE, 1'b0, "verify_bad");
    add(1,  4'h0, 4'h0, 4'h0, 4'h0, 0, 4'hF, 1'b0, "zero_word");
    add(2,  4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h0, 1'b1, "negzero");
    add(2,  4'h8, 4'h8, 4'h0, 4'h0, 0, 4'hE, 1'b0, "eac3");
    add(15, 4'h1, 4'h1, 4'h1, 4'h1, 0, 4'h0, 1'b1, "maxlen");
    add(2,  4'hF, 4'hF, 4'h0, 4'h0, 0, 4'h0, 1'b1, "ones_ones");

    for (int v = 0; v < nvec; v++) begin
      for (int i = 0; i < 15; i++) cur_w[i] = vecs[v].w[i];
      run_block(vecs[v].n, vecs[v].gap, 1'b0, vecs[v].exp_csum, vecs[v].exp_chk, vecs[v].name);
    end

    // All pairs, back-to-back; every third block also pokes start during ACC and DONE.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int m;
        m = a + b;
        if (m > 15) m = m - 15;
        cur_w[0] = 4'(a);
        cur_w[1] = 4'(b);
        run_block(2, 0, ((a + b) % 3) == 0, ~4'(m), m == 15,
                  $sformatf("pair_%0h_%0h", a, b));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
